cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
- Transmitting end of the common data bus (CDB). Every reservation station and the ROB snoop this bus as `cdb_itf.slv`.
- Collects completed results from N execution units, buffers each in a small per-source FIFO, and round-robin arbitrates.
- Drives at most one registered broadcast per cycle: `wr`, `tag`, `inst_id`, `wdata`.
- Guarantees every accepted result is broadcast exactly once, in per-source order. Reservation-station entries free on a tag match, so none may be lost or duplicated.

Parameters:
- N_SRC, 4, number of execution-unit result sources.
- TAG_W, 4, CDB tag width; tag 0 is reserved and means "no dependency".
- ROB_PTR_W, 4, ROB instruction-id width.
- DATA_W, 32, result data width.
- FIFO_DEPTH, 2, per-source result buffer entries; power of two, ≥ 2.

Ports:
- clk, in, 1, clock.
- rst, in, 1, reset: synchronous, active-high.
- src_req, in, N_SRC, per-source result valid.
- src_rdy, out, N_SRC, per-source buffer can accept.
- src_tag, in, N_SRC*TAG_W, packed result tags; source i occupies bits [i*TAG_W +: TAG_W].
- src_inst_id, in, N_SRC*ROB_PTR_W, packed ROB ids.
- src_wdata, in, N_SRC*DATA_W, packed result data.
- cdb_wr, out, 1, broadcast valid.
- cdb_tag, out, TAG_W, broadcast tag.
- cdb_inst_id, out, ROB_PTR_W, broadcast ROB id.
- cdb_wdata, out, DATA_W, broadcast data.
- err_tag0, out, 1, sticky: a tag-0 result was received.

Behaviour:
- Reset values:
  - All FIFOs empty; rr_ptr = 0.
  - cdb_wr = 0; cdb_tag = 0; cdb_inst_id = 0; cdb_wdata = 0; err_tag0 = 0.
  - src_rdy = all ones in the first cycle after reset.
- Reset mid-operation discards all buffered results; nothing is broadcast after reset deasserts until a new push.
- Accept:
  - Source i pushes when src_req[i] && src_rdy[i].
  - src_rdy[i] = ~full[i]. It is a function of FIFO count only, with no combinational path from any src_req or from the grant.
  - A full FIFO is not written in a cycle where it is also popped. Conservative; one bubble is acceptable.
- Arbitration, each cycle:
  - Candidates are the non-empty FIFOs.
  - Winner is the first candidate scanning i = rr_ptr, rr_ptr+1, …, wrapping mod N_SRC.
  - Winner's head is popped.
  - rr_ptr <= winner+1 mod N_SRC. rr_ptr is unchanged when there are no candidates.
- Broadcast:
  - Outputs are registered. The popped head appears on cdb_* with cdb_wr = 1 in the cycle after the pop.
  - Latency: push at edge of cycle t → earliest cdb_wr in cycle t+2.
  - Throughput: one result per cycle.
  - When there is no winner: cdb_wr = 0 and cdb_tag/inst_id/wdata are driven 0.
- Tag 0:
  - A popped entry with tag == 0 is consumed but not broadcast: cdb_wr = 0, fields 0.
  - err_tag0 is set and held until rst.
  - Rationale: tag 0 would falsely wake every ready operand in the snooping stations.
- Simultaneous push and pop on the same non-full FIFO is allowed; count is unchanged.
- FIFO pointers are PTR+1 bits wide with a wrap bit.
  - full = (wrap bits differ, indices equal); empty = (all equal).
- No stall input: the CDB is always accepted by its listeners.

Decomposition:
- Shared package cdb_pkg:
  - typedef cdb_pkt_t struct packed {tag, inst_id, wdata};
  - localparam CDB_TAG_NONE = 0.
- One sub-module: cdb_src_fifo, instantiated N_SRC times via generate.
  - Parameters: depth and width.
  - Ports: push, pkt_in, full, pop, pkt_out, empty.
- The round-robin scan and output register live in cdb_arbiter.

Test Plan:
- Single source: src_req[1] = 1 for one cycle with tag = 3, wdata = 0xDEADBEEF, inst_id = 5 at cycle 0 → cdb_wr = 1 at cycle 2 with tag 3, 0xDEADBEEF, id 5; cdb_wr = 0 at cycle 3.
- Contention: all 4 sources push one result in the same cycle (tags 1–4), rr_ptr = 0 → broadcasts on 4 consecutive cycles with tag order 1, 2, 3, 4; rr_ptr ends at 0.
- Fairness/wrap: source 3 and source 0 both push continuously → broadcasts alternate 3, 0, 3, 0 after the first grant; no source is starved.
- Backpressure: source 2 pushes 3 results in back-to-back cycles while source 0 holds its FIFO non-empty and wins → src_rdy[2] drops to 0 after 2 entries; the third is held by the source and broadcast later; order is preserved.
- Tag 0: source 1 pushes tag 0 → no cdb_wr for it; err_tag0 = 1 from the cycle after the pop and stays 1 until rst.
- Reset mid-operation: fill all FIFOs, assert rst for 1 cycle → cdb_wr = 0 and all src_rdy = 1 next cycle; no stale broadcasts appear afterward.

Source files
------------

// File: rtl/cdb_pkg.sv
// Shared types for the common data bus: the broadcast packet layout and the
// reserved "no dependency" tag value.
package cdb_pkg;

    localparam int CDB_TAG_W  = 4;
    localparam int CDB_ID_W   = 4;
    localparam int CDB_DATA_W = 32;

    localparam logic [CDB_TAG_W-1:0] CDB_TAG_NONE = '0;

    typedef struct packed {
        logic [CDB_TAG_W-1:0]  tag;
        logic [CDB_ID_W-1:0]   inst_id;
        logic [CDB_DATA_W-1:0] wdata;
    } cdb_pkt_t;

endpackage

// File: rtl/cdb_src_fifo.sv
// Small per-source result buffer with a show-ahead head. Pointers carry an
// extra wrap bit so full and empty are distinguishable without a counter.
module cdb_src_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 40
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] pkt_in,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] pkt_out,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign full    = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign pkt_out = mem_q[rd_ptr_q[PTR_W-1:0]];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: the pointers alone decide what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[PTR_W-1:0]] <= pkt_in;
    end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB transmitter: buffers execution-unit results per source, picks one per
// cycle round-robin and drives it as a registered broadcast.
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int N_SRC      = 4,
    parameter int TAG_W      = CDB_TAG_W,
    parameter int ROB_PTR_W  = CDB_ID_W,
    parameter int DATA_W     = CDB_DATA_W,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_SRC-1:0]        src_req,
    output logic [N_SRC-1:0]        src_rdy,
    input  logic [N_SRC*TAG_W-1:0]  src_tag,
    input  logic [N_SRC*ROB_PTR_W-1:0] src_inst_id,
    input  logic [N_SRC*DATA_W-1:0] src_wdata,
    output logic                    cdb_wr,
    output logic [TAG_W-1:0]        cdb_tag,
    output logic [ROB_PTR_W-1:0]    cdb_inst_id,
    output logic [DATA_W-1:0]       cdb_wdata,
    output logic                    err_tag0
);

    localparam int SEL_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam int PKT_W = $bits(cdb_pkt_t);

    cdb_pkt_t         pkt_in   [N_SRC];
    cdb_pkt_t         pkt_head [N_SRC];
    logic [N_SRC-1:0] full, empty, push, pop;

    logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [SEL_W-1:0] winner, cand;
    logic             found;
    cdb_pkt_t         head;
    cdb_pkt_t         cdb_pkt_q, cdb_pkt_d;
    logic             cdb_wr_q, cdb_wr_d;
    logic             err_tag0_q, err_tag0_d;

    // Ready depends only on occupancy, never on requests or the grant.
    assign src_rdy = ~full;
    assign push    = src_req & ~full;

    generate
        for (genvar gi = 0; gi < N_SRC; gi++) begin : g_src
            assign pkt_in[gi] = '{tag:     src_tag[gi*TAG_W +: TAG_W],
                                  inst_id: src_inst_id[gi*ROB_PTR_W +: ROB_PTR_W],
                                  wdata:   src_wdata[gi*DATA_W +: DATA_W]};

            cdb_src_fifo #(
                .DEPTH (FIFO_DEPTH),
                .WIDTH (PKT_W)
            ) u_fifo (
                .clk     (clk),
                .rst     (rst),
                .push    (push[gi]),
                .pkt_in  (pkt_in[gi]),
                .full    (full[gi]),
                .pop     (pop[gi]),
                .pkt_out (pkt_head[gi]),
                .empty   (empty[gi])
            );
        end
    endgenerate

    // First non-empty source at or after rr_ptr, wrapping.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int k = 0; k < N_SRC; k++) begin
            cand = SEL_W'((int'(rr_ptr_q) + k) % N_SRC);
            if (!found && !empty[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    assign pop  = found ? (N_SRC'(1) << winner) : '0;
    assign head = pkt_head[winner];

    always_comb begin
        cdb_wr_d   = 1'b0;
        cdb_pkt_d  = '0;
        err_tag0_d = err_tag0_q;
        rr_ptr_d   = rr_ptr_q;
        if (found) begin
            rr_ptr_d = (winner == SEL_W'(N_SRC-1)) ? '0 : winner + SEL_W'(1);
            // A tag-0 result would wake every waiting operand: drop it and flag.
            if (head.tag == CDB_TAG_NONE) begin
                err_tag0_d = 1'b1;
            end else begin
                cdb_wr_d  = 1'b1;
                cdb_pkt_d = head;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q   <= '0;
            cdb_wr_q   <= 1'b0;
            cdb_pkt_q  <= '0;
            err_tag0_q <= 1'b0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            cdb_wr_q   <= cdb_wr_d;
            cdb_pkt_q  <= cdb_pkt_d;
            err_tag0_q <= err_tag0_d;
        end
    end

    assign cdb_wr      = cdb_wr_q;
    assign cdb_tag     = cdb_pkt_q.tag;
    assign cdb_inst_id = cdb_pkt_q.inst_id;
    assign cdb_wdata   = cdb_pkt_q.wdata;
    assign err_tag0    = err_tag0_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: expected broadcasts are queued as stimulus
// is driven and compared in order as the bus reports them.
module tb_cdb_arbiter;
    import cdb_pkg::*;

    localparam int N = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  src_req = '0;
    logic [N-1:0]  src_rdy;
    logic [N*4-1:0]  src_tag = '0;
    logic [N*4-1:0]  src_inst_id = '0;
    logic [N*32-1:0] src_wdata = '0;
    logic          cdb_wr;
    logic [3:0]    cdb_tag;
    logic [3:0]    cdb_inst_id;
    logic [31:0]   cdb_wdata;
    logic          err_tag0;

    int        n_vec = 0;
    int        n_bad = 0;
    bit        mon_en = 1'b0;
    cdb_pkt_t  exp_q[$];
    int        s_cnt[N];
    logic [N-1:0] rdy_hist[256];

    always #5 clk = ~clk;

    cdb_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .src_req     (src_req),
        .src_rdy     (src_rdy),
        .src_tag     (src_tag),
        .src_inst_id (src_inst_id),
        .src_wdata   (src_wdata),
        .cdb_wr      (cdb_wr),
        .cdb_tag     (cdb_tag),
        .cdb_inst_id (cdb_inst_id),
        .cdb_wdata   (cdb_wdata),
        .err_tag0    (err_tag0)
    );

    task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    function automatic cdb_pkt_t mk(input logic [3:0] t, input logic [3:0] id, input logic [31:0] d);
        cdb_pkt_t p;
        p.tag = t; p.inst_id = id; p.wdata = d;
        return p;
    endfunction

    function automatic cdb_pkt_t gen(input int s, input int k);
        return mk(4'((s * 5 + k) % 15 + 1), 4'(k + s), 32'((s << 24) | (k << 8) | 8'hA5));
    endfunction

    task automatic drive(input int s, input cdb_pkt_t p);
        src_req[s] = 1'b1;
        src_tag[s*4 +: 4]      = p.tag;
        src_inst_id[s*4 +: 4]  = p.inst_id;
        src_wdata[s*32 +: 32]  = p.wdata;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench just after the edge that applied reset: cycle 0.
    task automatic do_reset();
        next_cycle();
        rst = 1'b1;
        src_req = '0;
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic wait_drain(input int max_cyc);
        int c = 0;
        while (exp_q.size() != 0 && c < max_cyc) begin
            @(posedge clk);
            c++;
        end
        @(negedge clk);
        check_eq("drain_left", 64'(exp_q.size()), 64'd0);
    endtask

    // Each source offers s_cnt[s] results back to back, holding a result
    // until the cycle in which it sees src_rdy.
    task automatic stream();
        int k[N];
        int c = 0;
        bit busy = 1'b1;
        for (int s = 0; s < N; s++) k[s] = 0;
        while (busy && c < 200) begin
            for (int s = 0; s < N; s++) begin
                if (k[s] < s_cnt[s]) drive(s, gen(s, k[s]));
                else src_req[s] = 1'b0;
            end
            @(negedge clk);
            if (c < 256) rdy_hist[c] = src_rdy;
            for (int s = 0; s < N; s++)
                if (src_req[s] && src_rdy[s]) k[s]++;
            next_cycle();
            c++;
            busy = 1'b0;
            for (int s = 0; s < N; s++) if (k[s] < s_cnt[s]) busy = 1'b1;
        end
        src_req = '0;
        check_eq("stream_done", 64'(c < 200), 64'd1);
    endtask

    // Every broadcast must match the head of the expected queue; idle cycles
    // must carry zeroed fields and none may appear when nothing is expected.
    always @(negedge clk) begin
        if (mon_en) begin
            if (cdb_wr) begin
                if (exp_q.size() == 0) begin
                    check_eq("spurious_wr", {cdb_tag, cdb_inst_id, cdb_wdata}, 64'd0);
                    check_eq("spurious_wr_flag", 64'(cdb_wr), 64'd0);
                end else begin
                    cdb_pkt_t e;
                    e = exp_q.pop_front();
                    check_eq("bcast_tag", 64'(cdb_tag), 64'(e.tag));
                    check_eq("bcast_id", 64'(cdb_inst_id), 64'(e.inst_id));
                    check_eq("bcast_data", 64'(cdb_wdata), 64'(e.wdata));
                end
            end else begin
                check_eq("idle_fields", {cdb_tag, cdb_inst_id, cdb_wdata}, 64'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        // Reset values
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        check_eq("rst_rdy", 64'(src_rdy), 64'hF);
        check_eq("rst_wr", 64'(cdb_wr), 64'd0);
        check_eq("rst_err", 64'(err_tag0), 64'd0);

        // Single source, two-cycle latency
        do_reset();
        drive(1, mk(4'd3, 4'd5, 32'hDEADBEEF));
        exp_q.push_back(mk(4'd3, 4'd5, 32'hDEADBEEF));
        next_cycle();
        src_req = '0;
        @(negedge clk); check_eq("single_c1_wr", 64'(cdb_wr), 64'd0);
        next_cycle();
        @(negedge clk); check_eq("single_c2_wr", 64'(cdb_wr), 64'd1);
        next_cycle();
        @(negedge clk); check_eq("single_c3_wr", 64'(cdb_wr), 64'd0);

        // Contention: all four at once, broadcast in source order
        do_reset();
        for (int s = 0; s < N; s++) begin
            drive(s, mk(4'(s + 1), 4'(s + 8), 32'hC0DE0000 + 32'(s)));
            exp_q.push_back(mk(4'(s + 1), 4'(s + 8), 32'hC0DE0000 + 32'(s)));
        end
        next_cycle();
        src_req = '0;
        for (int k = 0; k < N; k++) begin
            next_cycle();
            @(negedge clk);
            check_eq("cont_wr", 64'(cdb_wr), 64'd1);
            check_eq("cont_tag", 64'(cdb_tag), 64'(k + 1));
        end
        next_cycle();
        @(negedge clk); check_eq("cont_end_wr", 64'(cdb_wr), 64'd0);
        // rr_ptr wrapped to 0: source 0 must beat source 1
        next_cycle();
        drive(1, mk(4'd9, 4'd1, 32'h0000_0009));
        drive(0, mk(4'd8, 4'd0, 32'h0000_0008));
        exp_q.push_back(mk(4'd8, 4'd0, 32'h0000_0008));
        exp_q.push_back(mk(4'd9, 4'd1, 32'h0000_0009));
        next_cycle();
        src_req = '0;
        wait_drain(10);

        // Fairness across the wrap: sources 0 and 3 alternate
        do_reset();
        s_cnt = '{6, 0, 0, 6};
        for (int k = 0; k < 6; k++) begin
            exp_q.push_back(gen(0, k));
            exp_q.push_back(gen(3, k));
        end
        stream();
        wait_drain(40);

        // Backpressure on source 2 while source 0 competes
        do_reset();
        s_cnt = '{4, 0, 3, 0};
        exp_q.push_back(gen(0, 0)); exp_q.push_back(gen(2, 0));
        exp_q.push_back(gen(0, 1)); exp_q.push_back(gen(2, 1));
        exp_q.push_back(gen(0, 2)); exp_q.push_back(gen(2, 2));
        exp_q.push_back(gen(0, 3));
        stream();
        check_eq("bp_rdy2_c1", 64'(rdy_hist[1][2]), 64'd1);
        check_eq("bp_rdy2_c2", 64'(rdy_hist[2][2]), 64'd0);
        wait_drain(40);

        // Tag 0 is swallowed and flagged stickily
        do_reset();
        drive(1, mk(4'd0, 4'd2, 32'h1111_1111));
        next_cycle();
        drive(1, mk(4'd7, 4'd3, 32'h2222_2222));
        exp_q.push_back(mk(4'd7, 4'd3, 32'h2222_2222));
        @(negedge clk); check_eq("tag0_err_c1", 64'(err_tag0), 64'd0);
        next_cycle();
        src_req = '0;
        @(negedge clk);
        check_eq("tag0_err_c2", 64'(err_tag0), 64'd1);
        check_eq("tag0_wr_c2", 64'(cdb_wr), 64'd0);
        next_cycle();
        @(negedge clk); check_eq("tag0_wr_c3", 64'(cdb_wr), 64'd1);
        repeat (5) next_cycle();
        @(negedge clk); check_eq("tag0_err_held", 64'(err_tag0), 64'd1);
        do_reset();
        @(negedge clk); check_eq("tag0_err_cleared", 64'(err_tag0), 64'd0);

        // Reset mid-operation discards buffered results
        do_reset();
        for (int s = 0; s < N; s++) drive(s, gen(s, 0));
        exp_q.push_back(gen(0, 0));
        next_cycle();
        for (int s = 0; s < N; s++) drive(s, gen(s, 1));
        next_cycle();
        src_req = '0;
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check_eq("midrst_wr", 64'(cdb_wr), 64'd0);
        check_eq("midrst_rdy", 64'(src_rdy), 64'hF);
        repeat (10) next_cycle();
        check_eq("midrst_left", 64'(exp_q.size()), 64'd0);

        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
